// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM arbiter slice: the scheduler state
// encoding, the NOP command pattern and the SDRAM bus widths.
package sdram_arb_pkg;

   localparam int CMD_W  = 4;
   localparam int BA_W   = 2;
   localparam int ADDR_W = 13;

   // {cs_n, ras_n, cas_n, we_n} pattern driven while no generator owns the bus
   localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer. Counts while enabled, raises aref_pend every
// REF_PERIOD cycles and flags ref_overrun (sticky until reset) when an interval
// elapses while the previous refresh has still not been started.
module sdram_ref_timer #(
   parameter int REF_PERIOD = 750
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic aref_start,
   output logic aref_pend,
   output logic ref_overrun
);

   localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

   logic [CNT_W-1:0] ref_cnt;
   logic             wrap;

   assign wrap = (ref_cnt == CNT_LAST);

   // Interval counter plus pending/overrun flags; a wrap on the same edge as a
   // refresh start wins, so the new interval's request is never lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt     <= '0;
         aref_pend   <= 1'b0;
         ref_overrun <= 1'b0;
      end else if (!enable) begin
         ref_cnt <= '0;
      end else if (wrap) begin
         ref_cnt   <= '0;
         aref_pend <= 1'b1;
         if (aref_pend) begin
            ref_overrun <= 1'b1;
         end
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
         if (aref_start) begin
            aref_pend <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Central SDRAM command scheduler. Grants one of the init / auto-refresh /
// write / read generators at a time and muxes its bus onto the SDRAM pins.
// Refresh has priority, bursts are never preempted, and every grant is
// followed by at least one IDLE cycle.
// Grant handshake: a generator owns the bus while its *_en is high; *_en rises
// the cycle after the IDLE decision and falls on the edge that samples the
// matching one-cycle *_done pulse. Done pulses from non-granted generators
// are ignored.
// Build option: define SDRAM_ARB_RR_EN to alternate between write and read
// when both request at once (refresh priority is unchanged); otherwise write
// always wins over read.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int REF_PERIOD = 750
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_end,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_done,
   input  logic [CMD_W-1:0]  aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   input  logic              wr_done,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              rd_req,
   input  logic              rd_done,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic [CMD_W-1:0]  sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              ref_overrun,
   output arb_state_t        dbg_state,
   output logic              dbg_aref_pend
);

   arb_state_t state;
   logic       aref_pend;
   logic       timer_en;
   logic       aref_start;
   logic       wr_pick;
   logic       rd_pick;

   // The refresh interval only runs once the device is initialised.
   assign timer_en   = (state != INIT);
   // The edge that leaves IDLE for AREF consumes the pending refresh.
   assign aref_start = (state == IDLE) && aref_pend;

`ifdef SDRAM_ARB_RR_EN
   logic last_rd;
   // On a tie, serve whichever side did not get the previous data grant.
   assign wr_pick = wr_req && (!rd_req || last_rd);
`else
   assign wr_pick = wr_req;
`endif
   assign rd_pick = rd_req && !wr_pick;

   sdram_ref_timer #(
      .REF_PERIOD (REF_PERIOD)
   ) u_ref_timer (
      .clk         (clk),
      .rst         (rst),
      .enable      (timer_en),
      .aref_start  (aref_start),
      .aref_pend   (aref_pend),
      .ref_overrun (ref_overrun)
   );

   // Scheduler FSM with registered grants; a grant is only released by the
   // done pulse of the generator that holds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         aref_en <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
         last_rd <= 1'b0;
`endif
      end else begin
         case (state)
            INIT: begin
               if (init_end) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (aref_pend) begin
                  state   <= AREF;
                  aref_en <= 1'b1;
               end else if (wr_pick) begin
                  state <= WRITE;
                  wr_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                  last_rd <= 1'b0;
`endif
               end else if (rd_pick) begin
                  state <= READ;
                  rd_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                  last_rd <= 1'b1;
`endif
               end
            end
            AREF: begin
               if (aref_done) begin
                  state   <= IDLE;
                  aref_en <= 1'b0;
               end
            end
            WRITE: begin
               if (wr_done) begin
                  state <= IDLE;
                  wr_en <= 1'b0;
               end
            end
            READ: begin
               if (rd_done) begin
                  state <= IDLE;
                  rd_en <= 1'b0;
               end
            end
            default: begin
               state   <= INIT;
               aref_en <= 1'b0;
               wr_en   <= 1'b0;
               rd_en   <= 1'b0;
            end
         endcase
      end
   end

   // Command bus mux selected purely by the current state; IDLE drives NOP.
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_ba   = '0;
      sdram_addr = '0;
      case (state)
         INIT: begin
            sdram_cmd  = init_cmd;
            sdram_ba   = init_ba;
            sdram_addr = init_addr;
         end
         AREF: begin
            sdram_cmd  = aref_cmd;
            sdram_addr = aref_addr;
         end
         WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_ba   = wr_ba;
            sdram_addr = wr_addr;
         end
         READ: begin
            sdram_cmd  = rd_cmd;
            sdram_ba   = rd_ba;
            sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   assign dbg_state     = state;
   assign dbg_aref_pend = aref_pend;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter. A main instance (default refresh period) covers
// init, write/read/refresh scheduling and reset mid-burst; a second instance
// with a 16-cycle refresh period covers refresh pending/overrun timing.
// Grants of the main instance are checked by a negedge monitor against an
// expected queue filled by the stimulus.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int SB_W = 3 + CMD_W + BA_W + ADDR_W;

  localparam logic [CMD_W-1:0]  INIT_CMD  = 4'b0001;
  localparam logic [BA_W-1:0]   INIT_BA   = 2'b01;
  localparam logic [ADDR_W-1:0] INIT_ADDR = 13'h00aa;
  localparam logic [CMD_W-1:0]  AREF_CMD  = 4'b0010;
  localparam logic [ADDR_W-1:0] AREF_ADDR = 13'h0155;
  localparam logic [CMD_W-1:0]  WR_CMD    = 4'b0100;
  localparam logic [BA_W-1:0]   WR_BA     = 2'b10;
  localparam logic [ADDR_W-1:0] WR_ADDR   = 13'h0123;
  localparam logic [CMD_W-1:0]  RD_CMD    = 4'b0101;
  localparam logic [BA_W-1:0]   RD_BA     = 2'b11;
  localparam logic [ADDR_W-1:0] RD_ADDR   = 13'h1abc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, rst_t;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic init_end, aref_done, wr_req, wr_done, rd_req, rd_done;
  logic aref_en, wr_en, rd_en, ref_overrun, dbg_aref_pend;
  logic [CMD_W-1:0] sdram_cmd;
  logic [BA_W-1:0] sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  arb_state_t dbg_state;

  logic init_end_t, rd_req_t;
  logic aref_en_t, wr_en_t, rd_en_t, ref_overrun_t, aref_pend_t;
  logic [CMD_W-1:0] sdram_cmd_t;
  logic [BA_W-1:0] sdram_ba_t;
  logic [ADDR_W-1:0] sdram_addr_t;
  arb_state_t state_t;

  sdram_arbiter dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .init_cmd(INIT_CMD), .init_ba(INIT_BA), .init_addr(INIT_ADDR),
    .aref_done(aref_done), .aref_cmd(AREF_CMD), .aref_addr(AREF_ADDR),
    .wr_req(wr_req), .wr_done(wr_done), .wr_cmd(WR_CMD), .wr_ba(WR_BA), .wr_addr(WR_ADDR),
    .rd_req(rd_req), .rd_done(rd_done), .rd_cmd(RD_CMD), .rd_ba(RD_BA), .rd_addr(RD_ADDR),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .ref_overrun(ref_overrun), .dbg_state(dbg_state), .dbg_aref_pend(dbg_aref_pend)
  );

  sdram_arbiter #(.REF_PERIOD(16)) dut_t (
    .clk(clk), .rst(rst_t), .init_end(init_end_t),
    .init_cmd(INIT_CMD), .init_ba(INIT_BA), .init_addr(INIT_ADDR),
    .aref_done(1'b0), .aref_cmd(AREF_CMD), .aref_addr(AREF_ADDR),
    .wr_req(1'b0), .wr_done(1'b0), .wr_cmd(WR_CMD), .wr_ba(WR_BA), .wr_addr(WR_ADDR),
    .rd_req(rd_req_t), .rd_done(1'b0), .rd_cmd(RD_CMD), .rd_ba(RD_BA), .rd_addr(RD_ADDR),
    .aref_en(aref_en_t), .wr_en(wr_en_t), .rd_en(rd_en_t),
    .sdram_cmd(sdram_cmd_t), .sdram_ba(sdram_ba_t), .sdram_addr(sdram_addr_t),
    .ref_overrun(ref_overrun_t), .dbg_state(state_t), .dbg_aref_pend(aref_pend_t)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SB_W-1:0] exp_grant(input arb_state_t s);
    case (s)
      AREF:    return {AREF, AREF_CMD, 2'b00, AREF_ADDR};
      WRITE:   return {WRITE, WR_CMD, WR_BA, WR_ADDR};
      default: return {READ, RD_CMD, RD_BA, RD_ADDR};
    endcase
  endfunction

  // Monitor: every rising grant of the main instance must match the queue head;
  // both instances must never show two grants at once.
  logic p_aref = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
  always @(negedge clk) begin
    logic [SB_W-1:0] act, expv;
    if (!rst_t) begin
      checks++;
      if (int'(aref_en_t) + int'(wr_en_t) + int'(rd_en_t) > 1) begin
        fails++;
        $display("FAIL mutex_t: grants %b%b%b, expected at most one", aref_en_t, wr_en_t, rd_en_t);
      end
    end
    if (rst) begin
      p_aref = 1'b0; p_wr = 1'b0; p_rd = 1'b0;
    end else begin
      checks++;
      if (int'(aref_en) + int'(wr_en) + int'(rd_en) > 1) begin
        fails++;
        $display("FAIL mutex: grants %b%b%b, expected at most one", aref_en, wr_en, rd_en);
      end
      if ((aref_en && !p_aref) || (wr_en && !p_wr) || (rd_en && !p_rd)) begin
        act = {dbg_state, sdram_cmd, sdram_ba, sdram_addr};
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL grant_unexpected: got %0h, expected no grant (cycle %0d)", act, cyc);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            fails++;
            $display("FAIL grant_bus: got %0h, expected %0h (cycle %0d)", act, expv, cyc);
          end
        end
      end
      p_aref = aref_en; p_wr = wr_en; p_rd = rd_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic en_sel(input int sel);
    case (sel)
      0: return aref_en;
      1: return wr_en;
      2: return rd_en;
      default: return aref_en | wr_en | rd_en;
    endcase
  endfunction

  task automatic wait_en(input int sel, input int max, input string name);
    int n = 0;
    while (!en_sel(sel) && n < max) begin
      step(1);
      n++;
    end
    check(name, 32'(en_sel(sel)), 32'd1);
  endtask

  task automatic pulse(input int sel);
    case (sel)
      0: aref_done = 1'b1;
      1: wr_done = 1'b1;
      default: rd_done = 1'b1;
    endcase
    step(1);
    aref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
  endtask

  function automatic int active_sel();
    if (aref_en) return 0;
    if (rd_en) return 2;
    return 1;
  endfunction

  // ---------------- stimulus ----------------
  localparam int K = 21;  // cycle in which the main instance first shows IDLE
  int g, k5;
  logic held;

  initial begin
    rst = 1'b1; rst_t = 1'b1;
    init_end = 1'b0; aref_done = 1'b0; wr_req = 1'b0; wr_done = 1'b0;
    rd_req = 1'b0; rd_done = 1'b0; init_end_t = 1'b0; rd_req_t = 1'b0;

    // reset state
    step(3);
    check("rst_bus", 32'({dbg_state, sdram_cmd, sdram_ba, sdram_addr}),
          32'({INIT, INIT_CMD, INIT_BA, INIT_ADDR}));
    check("rst_grants", 32'({aref_en, wr_en, rd_en}), 32'd0);
    check("rst_overrun", 32'(ref_overrun), 32'd0);
    rst = 1'b0;

    // init handoff: init_end at cycle 20, IDLE at 21
    while (cyc < 20) step(1);
    check("init_hold", 32'(dbg_state), 32'(INIT));
    init_end = 1'b1;
    step(1);
    check("idle_bus", 32'({dbg_state, sdram_cmd, sdram_ba, sdram_addr}),
          32'({IDLE, 4'b0111, 2'b00, 13'd0}));

    // write grant, release, one IDLE cycle, re-grant
    exp_q.push_back(exp_grant(WRITE));
    wr_req = 1'b1;
    step(1);
    check("wr_latency", 32'(wr_en), 32'd1);
    step(3);
    exp_q.push_back(exp_grant(WRITE));
    pulse(1);
    check("wr_release", 32'({dbg_state, wr_en}), 32'({IDLE, 1'b0}));
    step(1);
    check("wr_regrant", 32'(wr_en), 32'd1);
    wr_req = 1'b0;
    pulse(2);  // stray rd_done during WRITE is ignored
    check("stray_rd_done", 32'({dbg_state, wr_en}), 32'({WRITE, 1'b1}));
    step(1);
    pulse(1);
    step(1);
    check("idle_no_req", 32'({dbg_state, aref_en, wr_en, rd_en}), 32'({IDLE, 3'b000}));

    // write and read together
`ifdef SDRAM_ARB_RR_EN
    exp_q.push_back(exp_grant(READ));
    exp_q.push_back(exp_grant(WRITE));
    exp_q.push_back(exp_grant(READ));
`else
    exp_q.push_back(exp_grant(WRITE));
    exp_q.push_back(exp_grant(WRITE));
    exp_q.push_back(exp_grant(WRITE));
`endif
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_en(3, 8, "both_grant");
      if (i == 2) begin wr_req = 1'b0; rd_req = 1'b0; end
      step(2);
      pulse(active_sel());
    end
    check("both_end", 32'(dbg_state), 32'(IDLE));

    // refresh becomes pending during a 512-cycle read; served before the write
    while (cyc < K + 400) step(1);
    exp_q.push_back(exp_grant(READ));
    exp_q.push_back(exp_grant(AREF));
    exp_q.push_back(exp_grant(WRITE));
    rd_req = 1'b1;
    wait_en(2, 8, "rd_grant");
    g = cyc;
    rd_req = 1'b0;
    wr_req = 1'b1;
    held = 1'b1;
    while (cyc < g + 511) begin
      if (!rd_en || aref_en || wr_en) held = 1'b0;
      if (cyc == K + 749) check("pend_before", 32'(dbg_aref_pend), 32'd0);
      if (cyc == K + 750) check("pend_set", 32'(dbg_aref_pend), 32'd1);
      step(1);
    end
    check("rd_held", 32'(held), 32'd1);
    pulse(2);
    check("rd_release", 32'({dbg_state, rd_en}), 32'({IDLE, 1'b0}));
    step(1);
    check("aref_first", 32'({aref_en, wr_en, dbg_aref_pend}), 32'({1'b1, 1'b0, 1'b0}));
    step(3);
    pulse(0);
    check("aref_release", 32'({dbg_state, aref_en}), 32'({IDLE, 1'b0}));
    step(1);
    check("wr_after_aref", 32'(wr_en), 32'd1);
    step(2);
    check("no_overrun", 32'(ref_overrun), 32'd0);

    // reset in the middle of a write burst
    rst = 1'b1; init_end = 1'b0; wr_req = 1'b0;
    step(1);
    check("rst_mid_wr", 32'({dbg_state, wr_en, ref_overrun}), 32'({INIT, 1'b0, 1'b0}));
    check("rst_mid_bus", 32'({sdram_cmd, sdram_ba, sdram_addr}), 32'({INIT_CMD, INIT_BA, INIT_ADDR}));
    rst = 1'b0;
    step(1);
    pulse(1);
    step(2);
    check("init_stray_done", 32'({dbg_state, aref_en, wr_en, rd_en}), 32'({INIT, 3'b000}));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // short refresh period: pending at +16, overrun at +32, sticky
    rst_t = 1'b0; init_end_t = 1'b1; rd_req_t = 1'b1;
    step(1);
    k5 = cyc;
    check("t_idle", 32'(state_t), 32'(IDLE));
    step(1);
    check("t_read", 32'({state_t, rd_en_t}), 32'({READ, 1'b1}));
    while (cyc < k5 + 40) begin
      if (cyc == k5 + 15) check("t_pend_before", 32'(aref_pend_t), 32'd0);
      if (cyc == k5 + 16) check("t_pend_set", 32'(aref_pend_t), 32'd1);
      if (cyc == k5 + 31) check("t_ovr_before", 32'(ref_overrun_t), 32'd0);
      if (cyc == k5 + 32) check("t_ovr_set", 32'(ref_overrun_t), 32'd1);
      step(1);
    end
    check("t_ovr_sticky", 32'({ref_overrun_t, rd_en_t, aref_en_t}), 32'({1'b1, 1'b1, 1'b0}));
    rst_t = 1'b1;
    step(1);
    check("t_rst", 32'({state_t, rd_en_t, ref_overrun_t, aref_pend_t}),
          32'({INIT, 1'b0, 1'b0, 1'b0}));
    check("t_rst_bus", 32'({sdram_cmd_t, sdram_ba_t, sdram_addr_t}),
          32'({INIT_CMD, INIT_BA, INIT_ADDR}));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // ---------------- time limit ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
